// File: rtl/tinysat_solver.sv
// Brute-force CNF SAT solver: streamed DIMACS-style literals, one candidate assignment per cycle.
// Define TINYSAT_COUNT_EN to run the exhaustive search and count every satisfying assignment.
module tinysat_solver #(
   parameter int NVARS       = 4,
   parameter int MAX_CLAUSES = 8,
   parameter int LIT_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic [LIT_W-1:0] data,
   output logic [NVARS-1:0] x,
   output logic             sol,
   output logic             done,
   output logic             busy,
   output logic             ovf,
   output logic [NVARS:0]   count
);

   localparam int NC_W = $clog2(MAX_CLAUSES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [NVARS:0] CAND_LAST = {1'b0, {NVARS{1'b1}}};

   logic [1:0]             state;
   logic [NVARS:0]         cand;
   logic [NC_W-1:0]        nclauses;
   logic [NVARS-1:0]       pos_mem [MAX_CLAUSES];
   logic [NVARS-1:0]       neg_mem [MAX_CLAUSES];
   logic [NVARS-1:0]       stage_pos;
   logic [NVARS-1:0]       stage_neg;

   logic [MAX_CLAUSES-1:0] clause_ok;
   logic                   all_sat;
   logic                   last_cand;
   logic [LIT_W-1:0]       mag;
   logic                   lit_zero;
   logic                   lit_bad;
   logic                   slot_free;

`ifdef TINYSAT_COUNT_EN
   logic                   found;
   logic [NVARS-1:0]       first_x;
`endif

   assign busy = (state == S_SEARCH);

   // The most negative literal negates to itself; as unsigned it exceeds NVARS and is rejected.
   assign mag       = data[LIT_W-1] ? -data : data;
   assign lit_zero  = (data == '0);
   assign lit_bad   = (mag > LIT_W'(NVARS));
   assign slot_free = (int'(nclauses) < MAX_CLAUSES);

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      clause_ok = '0;
      for (int i = 0; i < MAX_CLAUSES; i++) begin
         clause_ok[i] = (int'(nclauses) <= i)
                      | (|(pos_mem[i] & cand[NVARS-1:0]))
                      | (|(neg_mem[i] & ~cand[NVARS-1:0]));
      end
      all_sat   = &clause_ok;
      last_cand = (cand == CAND_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cand      <= '0;
         nclauses  <= '0;
         stage_pos <= '0;
         stage_neg <= '0;
         x         <= '0;
         sol       <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         // NOTE: clause storage is cleared on reset because rst must wipe the whole formula.
         for (int i = 0; i < MAX_CLAUSES; i++) begin
            pos_mem[i] <= '0;
            neg_mem[i] <= '0;
         end
`ifdef TINYSAT_COUNT_EN
         count     <= '0;
         found     <= 1'b0;
         first_x   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  state <= S_SEARCH;
                  cand  <= '0;
                  x     <= '0;
`ifdef TINYSAT_COUNT_EN
                  count <= '0;
                  found <= 1'b0;
`endif
               end
               if (load) begin
                  if (lit_zero) begin
                     if (slot_free) begin
                        for (int i = 0; i < MAX_CLAUSES; i++) begin
                           if (int'(nclauses) == i) begin
                              pos_mem[i] <= stage_pos;
                              neg_mem[i] <= stage_neg;
                           end
                        end
                        nclauses <= nclauses + NC_W'(1);
                     end else begin
                        ovf <= 1'b1;
                     end
                     stage_pos <= '0;
                     stage_neg <= '0;
                  end else if (lit_bad) begin
                     ovf <= 1'b1;
                  end else begin
                     for (int i = 0; i < NVARS; i++) begin
                        if (mag == LIT_W'(i + 1)) begin
                           if (data[LIT_W-1]) stage_neg[i] <= 1'b1;
                           else               stage_pos[i] <= 1'b1;
                        end
                     end
                  end
               end
            end

            S_SEARCH: begin
`ifdef TINYSAT_COUNT_EN
               if (all_sat) begin
                  count <= count + (NVARS+1)'(1);
                  if (!found) begin
                     found   <= 1'b1;
                     first_x <= cand[NVARS-1:0];
                  end
               end
               if (last_cand) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  sol   <= found | all_sat;
                  x     <= found ? first_x : (all_sat ? cand[NVARS-1:0] : '0);
               end else begin
                  cand <= cand + (NVARS+1)'(1);
               end
`else
               if (all_sat || last_cand) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  sol   <= all_sat;
                  x     <= all_sat ? cand[NVARS-1:0] : '0;
               end else begin
                  cand <= cand + (NVARS+1)'(1);
               end
`endif
            end

            S_DONE: begin
               if (!run) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
                  sol   <= 1'b0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef TINYSAT_COUNT_EN
   assign count = '0;
`endif

endmodule

// File: tb/tb_tinysat_solver.sv
// Directed bench for tinysat_solver (NVARS=4, MAX_CLAUSES=8, LIT_W=5), both macro settings.
module tb_tinysat_solver;

   localparam int NVARS       = 4;
   localparam int MAX_CLAUSES = 8;
   localparam int LIT_W       = 5;

`ifdef TINYSAT_COUNT_EN
   localparam bit COUNT_MODE = 1'b1;
`else
   localparam bit COUNT_MODE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic             load;
   logic [LIT_W-1:0] data;
   logic [NVARS-1:0] x;
   logic             sol;
   logic             done;
   logic             busy;
   logic             ovf;
   logic [NVARS:0]   count;

   int n_checks = 0;
   int n_errors = 0;
   int lat;
   logic clean;

   tinysat_solver #(
      .NVARS      (NVARS),
      .MAX_CLAUSES(MAX_CLAUSES),
      .LIT_W      (LIT_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .load (load),
      .data (data),
      .x    (x),
      .sol  (sol),
      .done (done),
      .busy (busy),
      .ovf  (ovf),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst  = 1'b1;
      run  = 1'b0;
      load = 1'b0;
      data = '0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic put(input int v);
      load = 1'b1;
      data = LIT_W'(v);
      tick;
      load = 1'b0;
      data = '0;
   endtask

   // Raises run; lat = edges after the one that sampled run until done is seen.
   task automatic search(output int lt, output logic ok);
      run = 1'b1;
      tick;
      lt = 0;
      ok = (busy === 1'b1) && (x === '0) && (done === 1'b0);
      while (done !== 1'b1 && lt < 64) begin
         tick;
         lt++;
         if (done !== 1'b1 && (busy !== 1'b1 || x !== '0)) ok = 1'b0;
      end
   endtask

   task automatic release_run;
      run = 1'b0;
      tick;
   endtask

   initial begin
      do_reset;
      check("reset x", 32'(x), 32'(0));
      check("reset sol", 32'(sol), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset busy", 32'(busy), 32'(0));
      check("reset ovf", 32'(ovf), 32'(0));
      check("reset count", 32'(count), 32'(0));

      // Test 1: (1|2)(-1)(-2|3) -> lowest solution 0110
      put(1); put(2); put(0); put(-1); put(0); put(-2); put(3); put(0);
      check("t1 ovf", 32'(ovf), 32'(0));
      search(lat, clean);
      check("t1 latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(7));
      check("t1 busy/x during search", 32'(clean), 32'(1));
      check("t1 sol", 32'(sol), 32'(1));
      check("t1 x", 32'(x), 32'(4'b0110));
      check("t1 busy after", 32'(busy), 32'(0));
      check("t1 count", 32'(count), COUNT_MODE ? 32'(2) : 32'(0));
      tick;
      check("t1 done persists", 32'(done), 32'(1));
      check("t1 x persists", 32'(x), 32'(4'b0110));
      release_run;
      check("t1 done cleared", 32'(done), 32'(0));
      check("t1 sol cleared", 32'(sol), 32'(0));
      check("t1 x held", 32'(x), 32'(4'b0110));

      // Test 2: (1)(-1) unsatisfiable
      do_reset;
      put(1); put(0); put(-1); put(0);
      search(lat, clean);
      check("t2 latency", 32'(lat), 32'(16));
      check("t2 busy/x during search", 32'(clean), 32'(1));
      check("t2 sol", 32'(sol), 32'(0));
      check("t2 x", 32'(x), 32'(0));
      check("t2 count", 32'(count), 32'(0));
      release_run;
      check("t2 done cleared", 32'(done), 32'(0));

      // Test 3: empty formula with a pending literal, then commit it and re-run
      do_reset;
      put(1);
      search(lat, clean);
      check("t3 latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(1));
      check("t3 sol", 32'(sol), 32'(1));
      check("t3 x", 32'(x), 32'(0));
      check("t3 count", 32'(count), COUNT_MODE ? 32'(16) : 32'(0));
      release_run;
      put(0);
      search(lat, clean);
      check("t3b latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(2));
      check("t3b x", 32'(x), 32'(1));
      check("t3b count", 32'(count), COUNT_MODE ? 32'(8) : 32'(0));
      release_run;

      // Test 4: storage overflow drops the ninth clause
      do_reset;
      for (int i = 0; i < MAX_CLAUSES; i++) begin
         put(1);
         put(0);
      end
      check("t4 ovf after 8 commits", 32'(ovf), 32'(0));
      put(-1);
      put(0);
      check("t4 ovf after 9th commit", 32'(ovf), 32'(1));
      search(lat, clean);
      check("t4 dropped clause absent sol", 32'(sol), 32'(1));
      check("t4 x", 32'(x), 32'(1));
      check("t4 latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(2));
      check("t4 ovf sticky", 32'(ovf), 32'(1));
      release_run;

      do_reset;
      check("t4 ovf reset", 32'(ovf), 32'(0));
      put(5);
      check("t4 ovf literal 5", 32'(ovf), 32'(1));
      put(2);
      put(0);
      search(lat, clean);
      check("t4 literal 5 ignored x", 32'(x), 32'(4'b0010));
      check("t4 literal 5 latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(3));
      check("t4 literal 5 count", 32'(count), COUNT_MODE ? 32'(8) : 32'(0));
      release_run;

      do_reset;
      put(-16);
      check("t4 ovf most negative", 32'(ovf), 32'(1));
      put(0);
      search(lat, clean);
      check("t4 empty clause latency", 32'(lat), 32'(16));
      check("t4 empty clause sol", 32'(sol), 32'(0));
      release_run;

      // Test 5: reset three cycles into a search
      do_reset;
      put(1); put(0); put(-1); put(0);
      run = 1'b1;
      tick;
      tick;
      tick;
      check("t5 busy before abort", 32'(busy), 32'(1));
      rst = 1'b1;
      run = 1'b0;
      tick;
      check("t5 abort x", 32'(x), 32'(0));
      check("t5 abort sol", 32'(sol), 32'(0));
      check("t5 abort done", 32'(done), 32'(0));
      check("t5 abort busy", 32'(busy), 32'(0));
      check("t5 abort ovf", 32'(ovf), 32'(0));
      check("t5 abort count", 32'(count), 32'(0));
      rst = 1'b0;
      search(lat, clean);
      check("t5 rerun latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(1));
      check("t5 rerun sol", 32'(sol), 32'(1));
      check("t5 rerun x", 32'(x), 32'(0));
      release_run;

      // Test 6: (1|2) counting
      do_reset;
      put(1); put(2); put(0);
      search(lat, clean);
      check("t6 latency", 32'(lat), COUNT_MODE ? 32'(16) : 32'(2));
      check("t6 count", 32'(count), COUNT_MODE ? 32'(12) : 32'(0));
      check("t6 x", 32'(x), 32'(4'b0001));
      check("t6 sol", 32'(sol), 32'(1));
      release_run;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
